// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state type, grant-index width helper and default
// width constants for the SDRAM channel arbiters.
package sdram_arb_pkg;

  localparam int DEF_NUM_MASTERS    = 3;
  localparam int DEF_ADDR_WIDTH     = 27;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Width of a master index; never narrower than one bit.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_channel_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner selection. The search starts
// at the master after last_grant and wraps around, so the most recently
// served master has the lowest priority.
module rr_picker
  import sdram_arb_pkg::*;
#(
  parameter int N       = DEF_NUM_MASTERS,
  parameter int GRANT_W = grant_w(N)
) (
  input  logic [N-1:0]       req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic               valid,
  output logic [GRANT_W-1:0] winner
);

  logic [GRANT_W-1:0] cand;

  // First requester at or after last_grant+1 (mod N) wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int off = 1; off <= N; off++) begin
      cand = GRANT_W'((int'(last_grant) + off) % N);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/sdram_channel_arbiter.sv
// sdram_channel_arbiter: round-robin arbitration of NUM_MASTERS requesters
// onto one SDRAM controller channel. Master 0 is the upload master; while
// upload is high only it may be granted. The granted request is registered
// onto the channel and held until sdram_done, then answered with a read-data
// register update and a one-cycle m_done pulse.
// Optional feature: define ARB_WATCHDOG_EN to add a BUSY watchdog that aborts
// a stalled transaction after TIMEOUT_CYCLES and raises sticky timeout_err.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | channel free; grant the round-robin winner when sdram_ready
// BUSY  | request held on the channel; wait for sdram_done (or watchdog)
// RESP  | m_done[grant] high for this one cycle; requests ignored
module sdram_channel_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = DEF_NUM_MASTERS,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   upload,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_data,
  input  logic [NUM_MASTERS-1:0]                 m_rnw,
  input  logic [NUM_MASTERS-1:0]                 m_ram_cs,
  output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_q,
  output logic [NUM_MASTERS-1:0]                 m_ready,
  output logic [NUM_MASTERS-1:0]                 m_done,
  output logic [ADDR_WIDTH-1:0]                  sdram_addr,
  output logic [DATA_WIDTH-1:0]                  sdram_data,
  output logic                                   sdram_rnw,
  output logic                                   sdram_ram_cs,
  output logic                                   sdram_sram_cs,
  input  logic [DATA_WIDTH-1:0]                  sdram_q,
  input  logic                                   sdram_ready,
  input  logic                                   sdram_done
`ifdef ARB_WATCHDOG_EN
  ,
  output logic                                   timeout_err
`endif
);

  localparam int GRANT_W = grant_w(NUM_MASTERS);
  localparam logic [NUM_MASTERS-1:0] UPLOAD_MASK = NUM_MASTERS'(1);
  localparam logic [GRANT_W-1:0]     LAST_RESET  = GRANT_W'(NUM_MASTERS - 1);

  arb_state_t              state;
  logic [GRANT_W-1:0]      grant;
  logic [GRANT_W-1:0]      last_grant;
  logic [NUM_MASTERS-1:0]  eligible;
  logic                    pick_valid;
  logic [GRANT_W-1:0]      pick_winner;

`ifdef ARB_WATCHDOG_EN
  localparam int WD_W = 16;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
`endif

  // The controller's ready is simply fanned out to every master.
  assign m_ready       = {NUM_MASTERS{sdram_ready}};
  assign sdram_sram_cs = 1'b0;

  // Upload mode narrows the candidate set to master 0 only.
  assign eligible = m_ram_cs & (upload ? UPLOAD_MASK : {NUM_MASTERS{1'b1}});

  rr_picker #(
    .N       (NUM_MASTERS),
    .GRANT_W (GRANT_W)
  ) u_rr_picker (
    .req        (eligible),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // Arbitration FSM; all channel and response outputs are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      grant        <= '0;
      last_grant   <= LAST_RESET;
      sdram_addr   <= '0;
      sdram_data   <= '0;
      sdram_rnw    <= 1'b0;
      sdram_ram_cs <= 1'b0;
      m_done       <= '0;
      m_q          <= '1;
`ifdef ARB_WATCHDOG_EN
      wd_cnt       <= '0;
      timeout_err  <= 1'b0;
`endif
    end else begin
      m_done <= '0;
      case (state)
        IDLE: begin
          if (pick_valid && sdram_ready) begin
            grant        <= pick_winner;
            sdram_addr   <= m_addr[pick_winner];
            sdram_data   <= m_data[pick_winner];
            sdram_rnw    <= m_rnw[pick_winner];
            sdram_ram_cs <= 1'b1;
`ifdef ARB_WATCHDOG_EN
            wd_cnt       <= WD_LOAD;
`endif
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (sdram_done) begin
            if (sdram_rnw) begin
              m_q[grant] <= sdram_q;
            end
            sdram_ram_cs  <= 1'b0;
            last_grant    <= grant;
            m_done[grant] <= 1'b1;
            state         <= RESP;
          end
`ifdef ARB_WATCHDOG_EN
          // Terminal count with no completion: give up and poison the read data.
          else if (wd_cnt == '0) begin
            m_q[grant]    <= '1;
            timeout_err   <= 1'b1;
            sdram_ram_cs  <= 1'b0;
            last_grant    <= grant;
            m_done[grant] <= 1'b1;
            state         <= RESP;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
`endif
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_channel_arbiter.sv
// tb_sdram_channel_arbiter: vector table, hand sequences and randomized
// transactions against a round-robin reference model for sdram_channel_arbiter.
module tb_sdram_channel_arbiter;

  localparam int NM = 3;
  localparam int AW = 27;
  localparam int DW = 8;
  localparam int TO = 16;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   upload = 1'b0;
  logic [NM-1:0][AW-1:0]  m_addr;
  logic [NM-1:0][DW-1:0]  m_data;
  logic [NM-1:0]          m_rnw;
  logic [NM-1:0]          m_ram_cs;
  logic [NM-1:0][DW-1:0]  m_q;
  logic [NM-1:0]          m_ready;
  logic [NM-1:0]          m_done;
  logic [AW-1:0]          sdram_addr;
  logic [DW-1:0]          sdram_data;
  logic                   sdram_rnw;
  logic                   sdram_ram_cs;
  logic                   sdram_sram_cs;
  logic [DW-1:0]          sdram_q;
  logic                   sdram_ready;
  logic                   sdram_done;
`ifdef ARB_WATCHDOG_EN
  logic                   timeout_err;
`endif

  always #5 clk = ~clk;

  sdram_channel_arbiter #(
    .NUM_MASTERS    (NM),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .upload        (upload),
    .m_addr        (m_addr),
    .m_data        (m_data),
    .m_rnw         (m_rnw),
    .m_ram_cs      (m_ram_cs),
    .m_q           (m_q),
    .m_ready       (m_ready),
    .m_done        (m_done),
    .sdram_addr    (sdram_addr),
    .sdram_data    (sdram_data),
    .sdram_rnw     (sdram_rnw),
    .sdram_ram_cs  (sdram_ram_cs),
    .sdram_sram_cs (sdram_sram_cs),
    .sdram_q       (sdram_q),
    .sdram_ready   (sdram_ready),
    .sdram_done    (sdram_done)
`ifdef ARB_WATCHDOG_EN
    ,
    .timeout_err   (timeout_err)
`endif
  );

  typedef struct {
    logic [2:0]  req;
    logic        up;
    logic [2:0]  rnw;
    int          rdy_hold;
    int          lat;
    logic [26:0] addr;
    logic [7:0]  wd;
    logic [7:0]  rd;
    int          exp_w;
    logic [23:0] q;      // {q2, q1, q0} after the transaction
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          last;
  logic [7:0]  exp_q [NM];
  vec_t        vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_q(input string tag);
    for (int i = 0; i < NM; i++) chk($sformatf("%s_q%0d", tag, i), m_q[i], exp_q[i]);
  endtask

  // Reference round-robin rule: scan from last+1 with wraparound; upload
  // restricts candidates to master 0.
  function automatic int model_pick(input logic [NM-1:0] pend, input logic up, input int lst);
    for (int off = 1; off <= NM; off++) begin
      int c;
      c = (lst + off) % NM;
      if (pend[c] && (!up || c == 0)) return c;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset_n     = 1'b0;
    m_ram_cs    = '0;
    upload      = 1'b0;
    sdram_done  = 1'b0;
    sdram_ready = 1'b1;
    sdram_q     = '0;
    step();
    step();
    reset_n = 1'b1;
    last = NM - 1;
    for (int i = 0; i < NM; i++) exp_q[i] = 8'hFF;
  endtask

  // One step from an IDLE decision cycle: the grant must be on the channel.
  task automatic expect_grant(input int w, input string tag);
    step();
    chk({tag, "_cs"}, sdram_ram_cs, 1);
    chk({tag, "_addr"}, sdram_addr, m_addr[w]);
    chk({tag, "_data"}, sdram_data, m_data[w]);
    chk({tag, "_rnw"}, sdram_rnw, m_rnw[w]);
  endtask

  // Called in the grant cycle; sdram_done arrives lat cycles later. Leaves the
  // bench in the following IDLE decision cycle with the winner's request dropped.
  task automatic complete(input int w, input int lat, input logic [7:0] rd, input bit hold_done,
                          input int drop_at, input int up_at, input logic up_val);
    for (int i = 0; i < lat; i++) begin
      if (i == drop_at) m_ram_cs[w] = 1'b0;
      if (i == up_at) upload = up_val;
      step();
      chk("busy_cs", sdram_ram_cs, 1);
      chk("busy_addr", sdram_addr, m_addr[w]);
      chk("busy_mdone", m_done, 0);
    end
    sdram_q    = rd;
    sdram_done = 1'b1;
    step();
    if (hold_done) sdram_q = ~rd;
    else sdram_done = 1'b0;
    chk("resp_cs", sdram_ram_cs, 0);
    chk("resp_mdone", m_done, NM'(1) << w);
    if (m_rnw[w]) exp_q[w] = rd;
    chk_q("resp");
    m_ram_cs[w] = 1'b0;
    last = w;
    step();
    sdram_done = 1'b0;
    chk("pulse_end", m_done, 0);
    chk_q("after");
  endtask

  initial begin
    int w;
    int n;
    int lat;
    logic [NM-1:0] pend;
    bit bad;
    vec_t rec;

    vecs[0] = '{req:3'b010, up:1'b0, rnw:3'b111, rdy_hold:0, lat:4, addr:27'h0001234, wd:8'h00, rd:8'h5A, exp_w:1, q:{8'hFF, 8'h5A, 8'hFF}};
    vecs[1] = '{req:3'b111, up:1'b1, rnw:3'b110, rdy_hold:0, lat:2, addr:27'h0000100, wd:8'hA5, rd:8'h33, exp_w:0, q:{8'hFF, 8'h5A, 8'hFF}};
    vecs[2] = '{req:3'b110, up:1'b0, rnw:3'b111, rdy_hold:0, lat:1, addr:27'h0000200, wd:8'h00, rd:8'h77, exp_w:1, q:{8'hFF, 8'h77, 8'hFF}};
    vecs[3] = '{req:3'b101, up:1'b0, rnw:3'b111, rdy_hold:3, lat:3, addr:27'h0000300, wd:8'h00, rd:8'hC3, exp_w:2, q:{8'hC3, 8'h77, 8'hFF}};
    vecs[4] = '{req:3'b011, up:1'b0, rnw:3'b011, rdy_hold:0, lat:1, addr:27'h0000400, wd:8'h00, rd:8'h11, exp_w:0, q:{8'hC3, 8'h77, 8'h11}};
    vecs[5] = '{req:3'b001, up:1'b0, rnw:3'b000, rdy_hold:0, lat:5, addr:27'h0000500, wd:8'h3C, rd:8'hEE, exp_w:0, q:{8'hC3, 8'h77, 8'h11}};
    vecs[6] = '{req:3'b100, up:1'b0, rnw:3'b100, rdy_hold:0, lat:1, addr:27'h0000600, wd:8'h00, rd:8'h00, exp_w:2, q:{8'h00, 8'h77, 8'h11}};
    vecs[7] = '{req:3'b110, up:1'b0, rnw:3'b110, rdy_hold:0, lat:2, addr:27'h0000700, wd:8'h00, rd:8'h9C, exp_w:1, q:{8'h00, 8'h9C, 8'h11}};

    m_addr = '0;
    m_data = '0;
    m_rnw  = '0;

    // Reset state
    do_reset();
    chk("rst_cs", sdram_ram_cs, 0);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_data", sdram_data, 0);
    chk("rst_rnw", sdram_rnw, 0);
    chk("rst_sram_cs", sdram_sram_cs, 0);
    chk("rst_mdone", m_done, 0);
    chk("rst_ready", m_ready, 3'b111);
    chk_q("rst");
`ifdef ARB_WATCHDOG_EN
    chk("rst_timeout", timeout_err, 0);
`endif

    // Vector table: single transactions from IDLE
    for (int v = 0; v < 8; v++) begin
      rec = vecs[v];
      for (int i = 0; i < NM; i++) begin
        m_addr[i] = rec.addr ^ (AW'(i ^ rec.exp_w) << 24);
        m_data[i] = rec.wd ^ DW'((i ^ rec.exp_w) << 4);
      end
      m_rnw    = rec.rnw;
      upload   = rec.up;
      m_ram_cs = rec.req;
      if (rec.rdy_hold > 0) begin
        sdram_ready = 1'b0;
        #1;
        chk("vec_ready_lo", m_ready, 3'b000);
        for (int j = 0; j < rec.rdy_hold; j++) begin
          step();
          chk("vec_no_grant", sdram_ram_cs, 0);
        end
        sdram_ready = 1'b1;
        #1;
        chk("vec_ready_hi", m_ready, 3'b111);
      end
      w = model_pick(rec.req, rec.up, last);
      chk("vec_model_w", w, rec.exp_w);
      expect_grant(rec.exp_w, "vec");
      complete(rec.exp_w, rec.lat, rec.rd, 1'b0, -1, -1, 1'b0);
      m_ram_cs = '0;
      upload   = 1'b0;
      for (int i = 0; i < NM; i++) chk($sformatf("vec%0d_q%0d", v, i), m_q[i], rec.q[8*i +: 8]);
    end

    // sdram_done in IDLE is ignored
    sdram_q    = 8'hDE;
    sdram_done = 1'b1;
    step();
    sdram_done = 1'b0;
    chk("idle_done_mdone", m_done, 0);
    chk("idle_done_cs", sdram_ram_cs, 0);
    step();
    chk_q("idle_done");

    // sdram_done held into RESP is ignored (no second capture, single pulse)
    m_addr[1] = 27'h0ABCDE; m_rnw = 3'b111; m_ram_cs = 3'b010;
    w = model_pick(3'b010, 1'b0, last);
    expect_grant(w, "hold");
    complete(w, 2, 8'h6B, 1'b1, -1, -1, 1'b0);

    // Continuous requests from reset: 0,1,2,0,1,2 with a 2-cycle gap
    do_reset();
    for (int i = 0; i < NM; i++) m_addr[i] = {3'(i), 24'h000010};
    m_rnw = 3'b111;
    m_ram_cs = 3'b111;
    for (int k = 0; k < 6; k++) begin
      expect_grant(k % 3, "cont");
      m_ram_cs = 3'b111;
      complete(k % 3, 1 + (k % 2), 8'(8'h20 + k), 1'b0, -1, -1, 1'b0);
    end

    // Upload restricts grants to master 0; masters 1,2 starve until it drops
    do_reset();
    for (int i = 0; i < NM; i++) m_addr[i] = {3'(i), 24'h000200};
    m_rnw = 3'b110; m_data[0] = 8'hA5;
    upload = 1'b1; m_ram_cs = 3'b111;
    expect_grant(0, "upl0");
    chk("upl0_wdata", sdram_data, 8'hA5);
    complete(0, 2, 8'h44, 1'b0, -1, -1, 1'b0);
    for (int j = 0; j < 5; j++) begin
      step();
      chk("upl_starve", sdram_ram_cs, 0);
    end
    upload = 1'b0;
    expect_grant(1, "upl1");
    complete(1, 1, 8'h55, 1'b0, -1, -1, 1'b0);
    // Upload rises while master 2 is BUSY, and master 2 drops its request mid-BUSY
    expect_grant(2, "upl2");
    m_ram_cs[0] = 1'b1;
    complete(2, 4, 8'h66, 1'b0, 2, 1, 1'b1);
    expect_grant(0, "upl_after");
    complete(0, 1, 8'h77, 1'b0, -1, -1, 1'b0);
    upload = 1'b0;

    // Reset asserted mid-BUSY
    m_rnw = 3'b111; m_ram_cs = 3'b010;
    w = model_pick(3'b010, 1'b0, last);
    expect_grant(w, "rstb");
    step();
    step();
    chk("rstb_busy", sdram_ram_cs, 1);
    reset_n = 1'b0;
    #1;
    chk("rstb_cs_now", sdram_ram_cs, 0);
    chk("rstb_mdone", m_done, 0);
    m_ram_cs = 3'b111;
    step();
    reset_n = 1'b1;
    last = NM - 1;
    for (int i = 0; i < NM; i++) exp_q[i] = 8'hFF;
    chk("rstb_rel_mdone", m_done, 0);
    chk_q("rstb");
    expect_grant(0, "rstb_first");
    complete(0, 1, 8'h12, 1'b0, -1, -1, 1'b0);
    m_ram_cs = '0;

`ifdef ARB_WATCHDOG_EN
    // Watchdog abort after TO BUSY cycles with no sdram_done
    m_addr[1] = 27'h0000777; m_rnw = 3'b111; m_ram_cs = 3'b010;
    w = model_pick(3'b010, 1'b0, last);
    expect_grant(w, "wd_pre");
    complete(w, 3, 8'h42, 1'b0, -1, -1, 1'b0);
    m_ram_cs[1] = 1'b1;
    expect_grant(1, "wd");
    n = 0;
    while (sdram_ram_cs === 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("wd_busy_cycles", n, TO);
    chk("wd_mdone", m_done, 3'b010);
    exp_q[1] = 8'hFF;
    chk_q("wd");
    chk("wd_err", timeout_err, 1);
    m_ram_cs = '0;
    repeat (5) step();
    chk("wd_pulse_end", m_done, 0);
    chk("wd_err_sticky", timeout_err, 1);
`else
    // No watchdog: BUSY waits indefinitely
    m_addr[1] = 27'h0000777; m_rnw = 3'b111; m_ram_cs = 3'b010;
    w = model_pick(3'b010, 1'b0, last);
    expect_grant(w, "nowd");
    bad = 1'b0;
    for (int j = 0; j < 300; j++) begin
      step();
      if (sdram_ram_cs !== 1'b1 || m_done !== '0) bad = 1'b1;
    end
    chk("nowd_hold", bad, 0);
    complete(w, 0, 8'h3A, 1'b0, -1, -1, 1'b0);
`endif

    // Randomized transactions against the round-robin model
    do_reset();
    pend = '0;
    for (int t = 0; t < 150; t++) begin
      for (int i = 0; i < NM; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i]   = 1'b1;
          m_addr[i] = {3'(i), 24'($urandom)};
          m_data[i] = 8'($urandom);
          m_rnw[i]  = 1'($urandom);
        end
      end
      if ((upload && !pend[0]) || pend == '0) begin
        pend[0]   = 1'b1;
        m_addr[0] = {3'd0, 24'($urandom)};
        m_data[0] = 8'($urandom);
        m_rnw[0]  = 1'($urandom);
      end
      m_ram_cs = pend;
      w = model_pick(pend, upload, last);
      expect_grant(w, "rnd");
      lat = $urandom_range(1, 6);
      complete(w, lat, 8'($urandom), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, lat - 1)) : -1,
               int'($urandom_range(0, lat - 1)), ($urandom_range(0, 3) == 0));
      pend[w] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends on its own.
  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sdram_channel_arbiter.md
# sdram_channel_arbiter

Parametrised successor to the fixed two-source SDRAM channel mux. It arbitrates `NUM_MASTERS` requesters onto one SDRAM controller channel using round-robin, with an `upload` override that restricts grants to master 0. Each granted request is registered, held on the channel until the controller reports completion, and answered with a per-master read-data register and a one-cycle done pulse. It sits between the MSX bus, upload and auxiliary masters and an SDRAM channel port.

## Interface
- `NUM_MASTERS`, 3: requesters, 2..8; master 0 is the upload master.
- `ADDR_WIDTH`, 27: SDRAM byte address width.
- `DATA_WIDTH`, 8: data width.
- `TIMEOUT_CYCLES`, 255: watchdog limit, used only with `ARB_WATCHDOG_EN`.

Ports:
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `upload` in 1: 1 = only master 0 is eligible for a grant.
- `m_addr` in NUM_MASTERS×ADDR_WIDTH: per-master address.
- `m_data` in NUM_MASTERS×DATA_WIDTH: per-master write data.
- `m_rnw` in NUM_MASTERS: 1 = read.
- `m_ram_cs` in NUM_MASTERS: request; held with addr/data/rnw stable until `m_done`.
- `m_q` out NUM_MASTERS×DATA_WIDTH: per-master read-data register.
- `m_ready` out NUM_MASTERS: broadcast copy of `sdram_ready`.
- `m_done` out NUM_MASTERS: one-cycle completion pulse.
- `sdram_addr`, `sdram_data`, `sdram_rnw`, `sdram_ram_cs`, `sdram_sram_cs` out: registered channel request; `sdram_sram_cs` is tied 0.
- `sdram_q` in DATA_WIDTH, `sdram_ready` in 1, `sdram_done` in 1: channel response.
- `timeout_err` out 1: sticky watchdog flag; only present with `ARB_WATCHDOG_EN`.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: eligible = `m_ram_cs` & (`upload` ? only bit 0 : all).
  - If eligible≠0 and `sdram_ready`, pick the winner in round-robin order, starting at `last_grant+1` mod NUM_MASTERS.
  - Latch the winner's addr/data/rnw into the `sdram_*` registers, set `sdram_ram_cs`=1, store `grant`, go to BUSY.
- BUSY: hold all `sdram_*` outputs stable. On `sdram_done`:
  - On a read, capture `sdram_q` into `m_q[grant]`.
  - Clear `sdram_ram_cs`, set `last_grant`=`grant`, go to RESP.
- RESP: pulse `m_done[grant]` for exactly this cycle, then return to IDLE.
- `m_q[i]` holds its value until the next read completion for master i. A write leaves `m_q` unchanged.
- A master that still has `m_ram_cs` high in the cycle after its `m_done` is treated as a new request. Masters must drop `m_ram_cs` in that cycle.
- A change on `upload` never aborts a transaction in flight. It affects only the next IDLE decision.
- A master dropping `m_ram_cs` during BUSY is ignored; the transaction completes and `m_done` still pulses.
- `sdram_done` seen in IDLE or RESP is ignored.
- Reset values: state IDLE; `last_grant`=NUM_MASTERS-1, so master 0 wins first; all `sdram_*`=0; `m_done`=0; `m_q`=all ones; `timeout_err`=0.
- Reset asserted mid-transaction drops `sdram_ram_cs` immediately, and no `m_done` is issued.

## Timing
- Request seen in IDLE at cycle 0 → `sdram_ram_cs`=1 at cycle 1.
- `sdram_done` at cycle k → `sdram_ram_cs`=0 and `m_q` updated at k+1 → `m_done` high during k+1 only.
- The earliest next grant is decided at k+2 and appears on the channel at k+3.
- `m_ready` is combinational, zero latency.

## Configuration
- `ARB_WATCHDOG_EN` defined:
  - An 8–16 bit counter runs in BUSY. If it reaches `TIMEOUT_CYCLES` without `sdram_done`, the transaction is aborted.
  - On abort: `sdram_ram_cs`=0, `m_q[grant]`=all ones, `timeout_err` is set (sticky until reset), and the FSM goes to RESP with the normal `m_done` pulse.
- Not defined: no counter and no `timeout_err` port; BUSY waits indefinitely.

## Structure
- `sdram_arb_pkg` holds:
  - the `arb_state_t` enum (IDLE/BUSY/RESP);
  - `GRANT_W = $clog2(NUM_MASTERS)` as a function or localparam helper;
  - the default width constants.
- Sub-module `rr_picker`: combinational; inputs `req` vector and `last_grant`; outputs `valid` and `winner` index. It is reused by later multi-channel arbiters.

## Test plan
- Reset, then master 1 reads 0x0001234 and the controller returns 0x5A with `sdram_done` 4 cycles after `sdram_ram_cs` → `sdram_addr`=0x0001234 at cycle 1; `m_q[1]`=0x5A; `m_done[1]` is a single pulse; `m_q[0]` and `m_q[2]` stay 0xFF.
- Masters 0, 1 and 2 request continuously from reset → grant order 0,1,2,0,1,2; each next `sdram_ram_cs` rises 2 cycles after the previous `m_done`.
- `upload`=1 with masters 1 and 2 requesting and master 0 writing 0xA5 → only master 0 is granted; masters 1 and 2 are starved until `upload`=0, then master 1 is granted next.
- `upload` rises while master 2 is in BUSY → master 2 completes with `m_done[2]`; the next grant goes to master 0.
- `reset_n` pulsed low in BUSY → `sdram_ram_cs`=0 immediately; no `m_done`; after release, master 0 is granted first.
- With `ARB_WATCHDOG_EN` and `TIMEOUT_CYCLES`=16, no `sdram_done` is returned → abort after 16 BUSY cycles; `m_done` pulses; `m_q`=0xFF; `timeout_err`=1 and stays 1.
